// File: rtl/network_interface.sv
// network_interface
//   AXI4-Lite slave bridging a CPU core to its NoC router port.
//   CPU stores to DATA queue 32-bit spike packets into a TX FIFO that drains
//   onto the router; router packets land in an RX FIFO popped by CPU loads
//   from DATA. A level interrupt flags pending RX packets.
//
// Register map (decoded on addr[3:2]):
//   0x0 DATA   W: push TX (SLVERR if full)   R: pop RX (SLVERR, 0 if empty)
//   0x4 STATUS R: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//               [15:8] tx_count [23:16] rx_count; writes ignored (OKAY)
//   0x8 CTRL   [0] irq_en (reset 1), written only when wstrb[0]=1
//   0xC        unmapped, SLVERR both ways
//
// Ports:
//   cpu_clk, cpu_rst_n          clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*       AXI4-Lite write address/data/response
//   axi_ar*/axi_r*              AXI4-Lite read address/data
//   net_tx_packet/valid/ready   TX FIFO head toward the router (FWFT)
//   net_rx_packet/valid/ready   packets arriving from the router
//   cpu_interrupt               irq_en && RX FIFO non-empty
//
// Handshakes: every channel transfers on a clock edge where valid && ready
// are both high. AW and W are accepted together only (awready = wready =
// awvalid && wvalid && !bvalid); AR is accepted while no read response is
// pending. B and R hold valid with stable payload until their ready.
module network_interface #(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int NEURON_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] net_tx_packet,
  output logic        net_tx_valid,
  input  logic        net_tx_ready,
  input  logic [31:0] net_rx_packet,
  input  logic        net_rx_valid,
  output logic        net_rx_ready,
  output logic        cpu_interrupt
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PAYLOAD_W = 32 - ROUTER_ADDR_WIDTH - NEURON_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [31:0]      tx_mem [FIFO_DEPTH];
  logic [31:0]      rx_mem [FIFO_DEPTH];
  logic [PTR_W:0]   tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             irq_en;

  logic        wr_accept, rd_accept;
  logic [1:0]  wr_sel, rd_sel;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data, status_word, tx_wpacket;

  assign tx_count = tx_wptr - tx_rptr;
  assign rx_count = rx_wptr - rx_rptr;
  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);

  // Ready outputs are forced low while reset is asserted.
  assign wr_accept   = cpu_rst_n && axi_awvalid && axi_wvalid && !axi_bvalid;
  assign rd_accept   = cpu_rst_n && axi_arvalid && !axi_rvalid;
  assign axi_awready = wr_accept;
  assign axi_wready  = wr_accept;
  assign axi_arready = cpu_rst_n && !axi_rvalid;

  assign wr_sel = axi_awaddr[3:2];
  assign rd_sel = axi_araddr[3:2];

  // Packet rebuilt from its router / neuron / payload fields; the fields are
  // carried transparently so this is the write data unchanged.
  assign tx_wpacket = {axi_wdata[31 -: ROUTER_ADDR_WIDTH],
                       axi_wdata[31-ROUTER_ADDR_WIDTH -: NEURON_ADDR_WIDTH],
                       axi_wdata[PAYLOAD_W-1:0]};

  // Full check uses the registered count, so a same-edge network pop does
  // not make room for the CPU push.
  assign tx_push = wr_accept && (wr_sel == REG_DATA) && !tx_full;
  assign tx_pop  = !tx_empty && net_tx_ready;
  assign rx_push = net_rx_valid && !rx_full;
  assign rx_pop  = rd_accept && (rd_sel == REG_DATA) && !rx_empty;

  assign net_tx_valid  = !tx_empty;
  assign net_tx_packet = tx_empty ? 32'h0 : tx_mem[tx_rptr[PTR_W-1:0]];
  assign net_rx_ready  = !rx_full;
  assign cpu_interrupt = irq_en && !rx_empty;

  assign status_word = {8'h00, 8'(rx_count), 8'(tx_count), 4'h0,
                        rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    wr_resp = RESP_SLVERR;
    case (wr_sel)
      REG_DATA:   wr_resp = tx_full ? RESP_SLVERR : RESP_OKAY;
      REG_STATUS: wr_resp = RESP_OKAY;
      REG_CTRL:   wr_resp = RESP_OKAY;
      default:    wr_resp = RESP_SLVERR;
    endcase
  end

  // Read data reflects state before any update on the accepting edge.
  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_SLVERR;
    case (rd_sel)
      REG_DATA: begin
        if (!rx_empty) begin
          rd_data = rx_mem[rx_rptr[PTR_W-1:0]];
          rd_resp = RESP_OKAY;
        end
      end
      REG_STATUS: begin
        rd_data = status_word;
        rd_resp = RESP_OKAY;
      end
      REG_CTRL: begin
        rd_data = {31'h0, irq_en};
        rd_resp = RESP_OKAY;
      end
      default: begin
        rd_data = 32'h0;
        rd_resp = RESP_SLVERR;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      tx_wptr    <= '0;
      tx_rptr    <= '0;
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      irq_en     <= 1'b1;
      axi_bvalid <= 1'b0;
      axi_bresp  <= 2'b00;
      axi_rvalid <= 1'b0;
      axi_rresp  <= 2'b00;
      axi_rdata  <= 32'h0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;

      if (wr_accept && (wr_sel == REG_CTRL) && axi_wstrb[0]) irq_en <= axi_wdata[0];

      // wr_accept implies !bvalid, so the two branches never overlap.
      if (wr_accept) begin
        axi_bvalid <= 1'b1;
        axi_bresp  <= wr_resp;
      end else if (axi_bready) begin
        axi_bvalid <= 1'b0;
      end

      if (rd_accept) begin
        axi_rvalid <= 1'b1;
        axi_rresp  <= rd_resp;
        axi_rdata  <= rd_data;
      end else if (axi_rready) begin
        axi_rvalid <= 1'b0;
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are visible.
  always_ff @(posedge cpu_clk) begin
    if (tx_push) tx_mem[tx_wptr[PTR_W-1:0]] <= tx_wpacket;
    if (rx_push) rx_mem[rx_wptr[PTR_W-1:0]] <= net_rx_packet;
  end

  logic unused_bits;
  assign unused_bits = ^{axi_awaddr[31:4], axi_awaddr[1:0],
                         axi_araddr[31:4], axi_araddr[1:0], axi_wstrb[3:1]};

endmodule

// File: tb/tb_network_interface.sv
module tb_network_interface;

  localparam int D = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        cpu_clk, cpu_rst_n;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [31:0] axi_araddr;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid, axi_rready;
  logic [31:0] net_tx_packet;
  logic        net_tx_valid, net_tx_ready;
  logic [31:0] net_rx_packet;
  logic        net_rx_valid, net_rx_ready;
  logic        cpu_interrupt;

  int checks = 0;
  int errors = 0;

  network_interface #(
    .ROUTER_ADDR_WIDTH(4),
    .NEURON_ADDR_WIDTH(12),
    .FIFO_DEPTH(D)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .net_tx_packet(net_tx_packet), .net_tx_valid(net_tx_valid),
    .net_tx_ready(net_tx_ready),
    .net_rx_packet(net_rx_packet), .net_rx_valid(net_rx_valid),
    .net_rx_ready(net_rx_ready),
    .cpu_interrupt(cpu_interrupt)
  );

  // ---------------- clock / reset ----------------
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model state after processing negedge N equals DUT state after posedge N+1.
  logic [31:0] tx_exp_q[$];
  logic [31:0] rx_exp_q[$];
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic        irq_m;
  int          tx_n, rx_n;
  logic        b_busy, r_busy, do_tx_push, do_rx_pop;
  logic [1:0]  m_resp;
  logic [31:0] m_data;
  logic [33:0] r_item;

  always @(negedge cpu_clk) begin
    if (!cpu_rst_n) begin
      tx_exp_q.delete(); rx_exp_q.delete(); b_exp_q.delete(); r_exp_q.delete();
      irq_m = 1'b1;
      chk("rst_awready", 32'(axi_awready), 32'h0);
      chk("rst_arready", 32'(axi_arready), 32'h0);
      chk("rst_bvalid", 32'(axi_bvalid), 32'h0);
      chk("rst_rvalid", 32'(axi_rvalid), 32'h0);
      chk("rst_bresp", 32'(axi_bresp), 32'h0);
      chk("rst_rresp", 32'(axi_rresp), 32'h0);
      chk("rst_rdata", axi_rdata, 32'h0);
      chk("rst_tx_valid", 32'(net_tx_valid), 32'h0);
      chk("rst_tx_packet", net_tx_packet, 32'h0);
      chk("rst_rx_ready", 32'(net_rx_ready), 32'h1);
      chk("rst_irq", 32'(cpu_interrupt), 32'h0);
    end else begin
      tx_n = tx_exp_q.size();
      rx_n = rx_exp_q.size();
      b_busy = (b_exp_q.size() > 0);
      r_busy = (r_exp_q.size() > 0);
      chk("tx_valid", 32'(net_tx_valid), 32'(tx_n > 0));
      if (tx_n > 0) chk("tx_packet", net_tx_packet, tx_exp_q[0]);
      chk("rx_ready", 32'(net_rx_ready), 32'(rx_n < D));
      chk("irq", 32'(cpu_interrupt), 32'(irq_m && rx_n > 0));
      chk("awready", 32'(axi_awready), 32'(axi_awvalid && axi_wvalid && !b_busy));
      chk("wready", 32'(axi_wready), 32'(axi_awvalid && axi_wvalid && !b_busy));
      chk("arready", 32'(axi_arready), 32'(!r_busy));
      chk("bvalid", 32'(axi_bvalid), 32'(b_busy));
      chk("rvalid", 32'(axi_rvalid), 32'(r_busy));
      if (axi_bvalid && axi_bready && b_busy) chk("bresp", 32'(axi_bresp), 32'(b_exp_q.pop_front()));
      if (axi_rvalid && axi_rready && r_busy) begin
        r_item = r_exp_q.pop_front();
        chk("rdata", axi_rdata, r_item[33:2]);
        chk("rresp", 32'(axi_rresp), 32'(r_item[1:0]));
      end
      // transactions taking effect on the coming edge, all judged on pre-edge state
      do_tx_push = 1'b0;
      do_rx_pop  = 1'b0;
      if (axi_arvalid && !r_busy) begin
        m_data = 32'h0;
        m_resp = SLVERR;
        case (axi_araddr[3:2])
          2'd0: if (rx_n > 0) begin m_data = rx_exp_q[0]; m_resp = OKAY; do_rx_pop = 1'b1; end
          2'd1: begin
            m_data = {8'h0, 8'(rx_n), 8'(tx_n), 4'h0,
                      rx_n == 0, rx_n == D, tx_n == 0, tx_n == D};
            m_resp = OKAY;
          end
          2'd2: begin m_data = {31'h0, irq_m}; m_resp = OKAY; end
          default: ;
        endcase
        r_exp_q.push_back({m_data, m_resp});
      end
      if (axi_awvalid && axi_wvalid && !b_busy) begin
        m_resp = SLVERR;
        case (axi_awaddr[3:2])
          2'd0: if (tx_n < D) begin m_resp = OKAY; do_tx_push = 1'b1; end
          2'd1: m_resp = OKAY;
          2'd2: begin m_resp = OKAY; if (axi_wstrb[0]) irq_m = axi_wdata[0]; end
          default: ;
        endcase
        b_exp_q.push_back(m_resp);
      end
      if (tx_n > 0 && net_tx_ready) void'(tx_exp_q.pop_front());
      if (do_tx_push) tx_exp_q.push_back(axi_wdata);
      if (do_rx_pop) void'(rx_exp_q.pop_front());
      if (net_rx_valid && rx_n < D) rx_exp_q.push_back(net_rx_packet);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_aw();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge cpu_clk);
      if (axi_awready) begin ok = 1'b1; break; end
    end
    @(posedge cpu_clk); #1;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    if (!ok) timeout("aw_accept");
  endtask

  task automatic wait_b(input int delay, output logic [1:0] resp);
    logic ok;
    ok = 1'b0;
    resp = 2'b11;
    repeat (delay) @(posedge cpu_clk);
    #1 axi_bready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge cpu_clk);
      if (axi_bvalid) begin resp = axi_bresp; ok = 1'b1; break; end
    end
    @(posedge cpu_clk); #1;
    axi_bready = 1'b0;
    if (!ok) timeout("b_response");
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int delay, output logic [1:0] resp);
    @(posedge cpu_clk); #1;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    wait_aw();
    wait_b(delay, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int delay,
                          output logic [31:0] data, output logic [1:0] resp);
    logic ok;
    @(posedge cpu_clk); #1;
    axi_araddr = addr; axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge cpu_clk);
      if (axi_arready) begin ok = 1'b1; break; end
    end
    @(posedge cpu_clk); #1;
    axi_arvalid = 1'b0;
    if (!ok) timeout("ar_accept");
    data = 32'hFFFF_FFFF; resp = 2'b11; ok = 1'b0;
    repeat (delay) @(posedge cpu_clk);
    #1 axi_rready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge cpu_clk);
      if (axi_rvalid) begin data = axi_rdata; resp = axi_rresp; ok = 1'b1; break; end
    end
    @(posedge cpu_clk); #1;
    axi_rready = 1'b0;
    if (!ok) timeout("r_response");
  endtask

  task automatic rx_send(input logic [31:0] pkt);
    @(posedge cpu_clk); #1;
    net_rx_valid = 1'b1; net_rx_packet = pkt;
    @(posedge cpu_clk); #1;
    net_rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge cpu_clk);
      if (!net_tx_valid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("tx_drain");
  endtask

  task automatic rand_writer(input int count);
    logic [31:0] addr;
    logic [1:0]  resp;
    int sel;
    for (int i = 0; i < count; i++) begin
      sel = $urandom_range(0, 9);
      addr = $urandom;
      addr[3:2] = (sel < 6) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
      repeat ($urandom_range(0, 2)) @(posedge cpu_clk);
      axi_write(addr, $urandom, 4'($urandom), $urandom_range(0, 2), resp);
    end
  endtask

  task automatic rand_reader(input int count);
    logic [31:0] addr, data;
    logic [1:0]  resp;
    int sel;
    for (int i = 0; i < count; i++) begin
      sel = $urandom_range(0, 9);
      addr = $urandom;
      addr[3:2] = (sel < 6) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
      repeat ($urandom_range(0, 2)) @(posedge cpu_clk);
      axi_read(addr, $urandom_range(0, 2), data, resp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  logic [31:0] pk[5];

  initial begin : main
    logic [1:0]  resp;
    logic [31:0] data;
    cpu_rst_n = 1'b0;
    axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    net_tx_ready = 1'b0; net_rx_packet = '0; net_rx_valid = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1 cpu_rst_n = 1'b1;

    vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, OKAY,   32'h0000_000A};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, OKAY,   32'h0000_0001};
    vecs[2]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, SLVERR, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, SLVERR, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, SLVERR, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, OKAY,   32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, OKAY,   32'h0000_000A};
    vecs[7]  = '{1'b1, 32'h0000_0008, 32'h0,         4'hE, OKAY,   32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, OKAY,   32'h0000_0001};
    vecs[9]  = '{1'b1, 32'h0000_0008, 32'h0,         4'h1, OKAY,   32'h0};
    vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, OKAY,   32'h0};
    vecs[11] = '{1'b1, 32'hF000_0008, 32'h0000_0001, 4'h1, OKAY,   32'h0};
    vecs[12] = '{1'b0, 32'h0000_0038, 32'h0,         4'h0, OKAY,   32'h0000_0001};
    vecs[13] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'h0, OKAY,   32'h0};
    vecs[14] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, OKAY,   32'h0000_0108};
    vecs[15] = '{1'b1, 32'h0000_0003, 32'hCAFE_F00D, 4'hF, OKAY,   32'h0};
    vecs[16] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, OKAY,   32'h0000_0208};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, i % 3, data, resp);
        chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
        chk($sformatf("vec%0d_rdata", i), data, vecs[i].rdata);
      end
    end
    net_tx_ready = 1'b1;
    wait_tx_drain();

    // single write drains straight through
    axi_write(32'h0, 32'h1234_5678, 4'hF, 0, resp);
    chk("single_write_bresp", 32'(resp), 32'(OKAY));
    wait_tx_drain();
    axi_read(32'h4, 0, data, resp);
    chk("status_after_drain", data, 32'h0000_000A);

    // RX single packet, interrupt one cycle later, pop, then empty read
    rx_send(32'hABCD_EF01);
    @(negedge cpu_clk);
    chk("irq_after_rx", 32'(cpu_interrupt), 32'h1);
    axi_read(32'h0, 0, data, resp);
    chk("rx_pop_data", data, 32'hABCD_EF01);
    chk("rx_pop_resp", 32'(resp), 32'(OKAY));
    @(negedge cpu_clk);
    chk("irq_cleared", 32'(cpu_interrupt), 32'h0);
    axi_read(32'h0, 0, data, resp);
    chk("rx_empty_data", data, 32'h0);
    chk("rx_empty_resp", 32'(resp), 32'(SLVERR));

    // TX overflow with router stalled, then in-order drain
    net_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      axi_write(32'h0, 32'h5000_0000 + 32'(i), 4'hF, 0, resp);
      chk($sformatf("tx_fill%0d_bresp", i), 32'(resp), 32'((i < 4) ? OKAY : SLVERR));
    end
    axi_read(32'h4, 0, data, resp);
    chk("status_tx_full", data, 32'h0000_0409);
    net_tx_ready = 1'b1;
    wait_tx_drain();

    // full TX refuses a push even when the router pops on the same edge
    net_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) axi_write(32'h0, 32'h6000_0000 + 32'(i), 4'hF, 0, resp);
    @(posedge cpu_clk); #1;
    axi_awaddr = 32'h0; axi_wdata = 32'hDEAD_0005; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; net_tx_ready = 1'b1;
    wait_aw();
    wait_b(0, resp);
    chk("full_push_with_pop", 32'(resp), 32'(SLVERR));
    wait_tx_drain();

    // RX fills, fifth packet held off, interrupt masked, ordered drain
    pk[0] = 32'h1110_0001; pk[1] = 32'h2220_0002; pk[2] = 32'h3330_0003;
    pk[3] = 32'h4440_0004; pk[4] = 32'h5550_0005;
    for (int i = 0; i < 5; i++) begin
      @(posedge cpu_clk); #1;
      net_rx_valid = 1'b1; net_rx_packet = pk[i];
    end
    @(negedge cpu_clk);
    chk("rx_full_ready", 32'(net_rx_ready), 32'h0);
    axi_write(32'h8, 32'h0, 4'h1, 0, resp);
    @(negedge cpu_clk);
    chk("irq_masked", 32'(cpu_interrupt), 32'h0);
    axi_read(32'h4, 0, data, resp);
    chk("status_rx_full", data, 32'h0004_0006);
    for (int i = 0; i < 5; i++) begin
      axi_read(32'h0, 1, data, resp);
      chk($sformatf("rx_drain%0d", i), data, (i == 0) ? pk[0] : pk[i]);
      if (i == 0) begin
        repeat (2) @(posedge cpu_clk);
        #1 net_rx_valid = 1'b0;
      end
    end
    axi_write(32'h8, 32'h1, 4'h1, 0, resp);

    // reset with FIFOs occupied and a write response pending
    net_tx_ready = 1'b0;
    axi_write(32'h0, 32'h7000_0001, 4'hF, 0, resp);
    axi_write(32'h0, 32'h7000_0002, 4'hF, 0, resp);
    rx_send(32'h8000_0001);
    rx_send(32'h8000_0002);
    @(posedge cpu_clk); #1;
    axi_awaddr = 32'h0; axi_wdata = 32'h7000_0003; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    wait_aw();
    cpu_rst_n = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1 cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
    chk("post_reset_bvalid", 32'(axi_bvalid), 32'h0);
    chk("post_reset_tx_valid", 32'(net_tx_valid), 32'h0);
    axi_read(32'h4, 0, data, resp);
    chk("post_reset_status", data, 32'h0000_000A);

    // randomized traffic on all four channels at once
    fork
      rand_writer(60);
      rand_reader(60);
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge cpu_clk); #1;
          net_rx_valid = ($urandom_range(0, 2) == 0);
          net_rx_packet = $urandom;
        end
        net_rx_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge cpu_clk); #1;
          net_tx_ready = 1'($urandom_range(0, 1));
        end
        net_tx_ready = 1'b1;
      end
    join
    for (int i = 0; i < D + 1; i++) axi_read(32'h0, 0, data, resp);
    repeat (5) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("end_b_outstanding", 32'(b_exp_q.size()), 32'h0);
    chk("end_r_outstanding", 32'(r_exp_q.size()), 32'h0);
    chk("end_tx_valid", 32'(net_tx_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
